// File: rtl/serial_adder_subtractor.sv
// serial_adder_subtractor
// Multi-cycle WIDTH-bit adder/subtractor. Each clock evaluates BITS_PER_CYCLE
// full-adder slices, starting at the LSB. Operands are captured on start. The
// result, carry and signed overflow are published together on a one-cycle
// done pulse. Subtraction is done as A + ~B + 1, so Cout=1 means no borrow.
module serial_adder_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic [BITS_PER_CYCLE:0]   slice_c;
    logic [WIDTH-1:0]          sum_wide;
    logic [WIDTH-1:0]          res_next;
    logic                      last_beat;

    // One-bit full-adder sum.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // One-bit full-adder carry (majority of the three inputs).
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Ripple the running carry through this beat's slices; the operand
    // registers shift right, so the current slice is always at bit 0.
    always_comb begin
        slice_sum  = '0;
        slice_c    = '0;
        slice_c[0] = carry_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            slice_sum[i]  = fa_sum(a_q[i], b_q[i], slice_c[i]);
            slice_c[i+1]  = fa_carry(a_q[i], b_q[i], slice_c[i]);
        end
    end

    // Sum bits enter the result register from the top. After N beats the
    // first slice has been shifted down to bit 0.
    always_comb begin
        sum_wide  = WIDTH'(slice_sum);
        res_next  = (res_q >> BITS_PER_CYCLE) | (sum_wide << (WIDTH - BITS_PER_CYCLE));
        last_beat = (cnt_q == CNT_W'(N - 1));
    end

    // Control FSM and datapath. Outputs are registered and change only on
    // completion, so partial sums stay internal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= Sub ? ~B : B;
                        carry_q <= Sub ? 1'b1 : Cin;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> BITS_PER_CYCLE;
                    b_q     <= b_q >> BITS_PER_CYCLE;
                    carry_q <= slice_c[BITS_PER_CYCLE];
                    res_q   <= res_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_beat) begin
                        // On the final beat the top slice bit is the MSB, so
                        // overflow is the carry into it XOR the carry out of it.
                        S     <= res_next;
                        Cout  <= slice_c[BITS_PER_CYCLE];
                        Ovf   <= slice_c[BITS_PER_CYCLE] ^ slice_c[BITS_PER_CYCLE-1];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
